pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and stall controller for the five-stage ARM pipeline. Drives load enables, flush and bubble-select lines for the PC, IF/ID, ID/EX and EX/MEM pipeline registers. Resolves load-use hazards with a one-cycle bubble, flushes wrong-path instructions on a taken branch, and freezes the pipeline while a data-memory access waits. A timeout on memory waits raises a sticky fault, and a saturating counter records stall cycles.

## Interface
- MEM_TIMEOUT, 16: maximum number of consecutive MEM_WAIT cycles before the controller declares a fault (valid range 1 to 2^COUNT_W-1).
- COUNT_W, 16: width of the wait counter and the stall counter.

- clk  in  1  Pipeline clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-low reset (asserted when 0).
- id_rn, id_rm  in  4  Source register numbers of the instruction in ID.
- id_uses_rn, id_uses_rm  in  1  The ID instruction actually reads the matching source.
- ex_rd  in  4  Destination register of the instruction in EX.
- ex_reg_write_enable, ex_mem_enable, ex_mem_rw  in  1  Control bits of the EX instruction, taken from the ID/EX outputs; mem_rw 0 = read (load), 1 = write.
- branch_taken  in  1  A branch resolved taken in EX this cycle.
- mem_req  in  1  The MEM stage is performing a data-memory access this cycle.
- mem_ready  in  1  Data memory completes the access this cycle.
- pc_load_enable  out  1  PC may update.
- if_id_load_enable  out  1  IF/ID register may load.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_load_enable  out  1  ID/EX register may load.
- id_ex_nop_select  out  1  ID/EX loads all-zero control signals (a bubble).
- ex_mem_hold  out  1  EX/MEM and MEM/WB hold their contents.
- mem_fault  out  1  Sticky fault flag: the memory wait timed out.
- stall_count  out  COUNT_W  Saturating count of cycles in which the PC was held.

## Operation
- FSM states: RUN, MEM_WAIT, FAULT. Registered state; outputs are Mealy, a function of the current state and the current inputs.
- Definitions used below:
  - load_use = ex_mem_enable & !ex_mem_rw & ex_reg_write_enable & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)).
  - freeze = (state==MEM_WAIT) | (state==FAULT) | (state==RUN & mem_req & !mem_ready).
- Default outputs: all load enables 1; if_id_flush, id_ex_nop_select and ex_mem_hold all 0.
- Priority order, highest first:
  1. freeze: pc_load_enable=0, if_id_load_enable=0, id_ex_load_enable=0, ex_mem_hold=1. Flush and NOP lines stay 0. branch_taken and load_use are ignored; the instructions involved are held and re-evaluated on release.
  2. branch_taken: if_id_flush=1 and id_ex_nop_select=1. The PC loads the branch target.
  3. load_use: pc_load_enable=0, if_id_load_enable=0, id_ex_nop_select=1. Exactly one bubble; the next cycle the load sits in MEM and load_use is false.
- State transitions:
  - RUN to MEM_WAIT when mem_req & !mem_ready.
  - MEM_WAIT to RUN when mem_ready=1. That cycle is still frozen; the pipeline advances the cycle after.
  - MEM_WAIT to FAULT when wait_cnt reaches MEM_TIMEOUT-1 with mem_ready=0. mem_ready wins if both happen in the same cycle.
  - FAULT exits only through reset.
- wait_cnt:
  - Cleared on entry to MEM_WAIT.
  - Increments each cycle spent in MEM_WAIT with mem_ready=0.
  - Always compared at full COUNT_W width.
- mem_fault = (state==FAULT).
- stall_count increments on every clock edge where pc_load_enable was 0, including load-use bubbles and freezes. It saturates at 2^COUNT_W-1 and never wraps.
- A branch_taken that coincides with load_use flushes the pipeline and inserts no stall; the dependent instruction is on the wrong path.

## Timing
- Outputs are combinational with zero latency from inputs. State, wait_cnt and stall_count update on the rising edge of clk.
- Reset asserted (asynchronous, independent of clk):
  - state=RUN, wait_cnt=0, stall_count=0, mem_fault=0.
  - Outputs forced: all load enables 0, if_id_flush=1, id_ex_nop_select=1, ex_mem_hold=0.
- Reset released: normal Mealy operation from RUN on the first clock edge. Reset in the middle of MEM_WAIT or FAULT discards the wait and clears the fault.
- A single-cycle memory access (mem_req & mem_ready in the same cycle) causes no stall.
- A wait with mem_ready arriving after k cycles freezes the pipeline for exactly k+1 cycles.

## Test plan
- Load-use: EX has an LDR writing r3 (mem_enable=1, rw=0, rwe=1); ID reads r3 on rn. Required: one cycle with pc_load_enable=0, if_id_load_enable=0 and id_ex_nop_select=1. The following cycle returns to normal. stall_count reads 1.
- Store in EX to r3 (rw=1) with ID reading r3 -> no stall. Also: a load to r3 while ID uses only rm=r4 -> no stall.
- branch_taken=1 together with load_use -> if_id_flush=1, id_ex_nop_select=1, pc_load_enable=1. stall_count is unchanged.
- mem_req=1 with mem_ready low for 3 cycles, then high -> freeze for 4 cycles (ex_mem_hold=1, all enables 0) and branch_taken ignored throughout. Back to RUN afterwards; stall_count reads 4.
- MEM_TIMEOUT=4 with mem_ready held at 0 -> mem_fault=1 from cycle 5 onward and stays set. Asserting reset low clears it and returns the outputs to the reset values immediately, without waiting for a clock edge.
- COUNT_W=3 with 10 consecutive freeze cycles -> stall_count saturates at 7.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the five-stage pipeline.
// The controller resolves load-use hazards with a single bubble.
// It flushes the wrong-path instructions when a branch is taken.
// It freezes the pipeline while a data-memory access is waiting.
// A memory wait that runs too long sets a sticky fault.
// A saturating counter records the cycles in which the PC was held.
//
// Handshake: there is no valid/ready pair on this block. Every output is a
// combinational decision for the current cycle. The pipeline acts on that
// decision at the next rising edge of clk.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         id_rn,
    input  logic [3:0]         id_rm,
    input  logic               id_uses_rn,
    input  logic               id_uses_rm,
    input  logic [3:0]         ex_rd,
    input  logic               ex_reg_write_enable,
    input  logic               ex_mem_enable,
    input  logic               ex_mem_rw,
    input  logic               branch_taken,
    input  logic               mem_req,
    input  logic               mem_ready,
    output logic               pc_load_enable,
    output logic               if_id_load_enable,
    output logic               if_id_flush,
    output logic               id_ex_load_enable,
    output logic               id_ex_nop_select,
    output logic               ex_mem_hold,
    output logic               mem_fault,
    output logic [COUNT_W-1:0] stall_count,
    output logic [1:0]         fsm_state
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FAULT    = 2'd2;

    // The wait counter is compared against this value at full width.
    localparam logic [COUNT_W-1:0] WAIT_LAST = COUNT_W'(MEM_TIMEOUT - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [COUNT_W-1:0] wait_cnt;
    logic               load_use;
    logic               freeze;

    // A hazard exists only when EX holds a load that writes a register the ID instruction reads.
    assign load_use = ex_mem_enable & ~ex_mem_rw & ex_reg_write_enable &
                      ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));

    assign freeze = (state == ST_MEM_WAIT) | (state == ST_FAULT) |
                    ((state == ST_RUN) & mem_req & ~mem_ready);

    assign mem_fault = (state == ST_FAULT);
    assign fsm_state = state;

    // Mealy output decode: reset override, then freeze > branch > load-use.
    always_comb begin
        pc_load_enable    = 1'b1;
        if_id_load_enable = 1'b1;
        if_id_flush       = 1'b0;
        id_ex_load_enable = 1'b1;
        id_ex_nop_select  = 1'b0;
        ex_mem_hold       = 1'b0;
        if (!reset) begin
            // Hold the front end and inject NOPs while reset is asserted.
            pc_load_enable    = 1'b0;
            if_id_load_enable = 1'b0;
            id_ex_load_enable = 1'b0;
            if_id_flush       = 1'b1;
            id_ex_nop_select  = 1'b1;
        end else if (freeze) begin
            // Nothing moves. A pending branch or hazard is evaluated again after release.
            pc_load_enable    = 1'b0;
            if_id_load_enable = 1'b0;
            id_ex_load_enable = 1'b0;
            ex_mem_hold       = 1'b1;
        end else if (branch_taken) begin
            // A dependent instruction is on the wrong path, so no bubble is needed.
            if_id_flush       = 1'b1;
            id_ex_nop_select  = 1'b1;
        end else if (load_use) begin
            pc_load_enable    = 1'b0;
            if_id_load_enable = 1'b0;
            id_ex_nop_select  = 1'b1;
        end
    end

    // Next-state logic. When mem_ready and the timeout coincide, mem_ready wins.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (mem_req && !mem_ready) state_next = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (mem_ready)                  state_next = ST_RUN;
                else if (wait_cnt == WAIT_LAST) state_next = ST_FAULT;
            end
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_RUN;
        endcase
    end

    // State register. Only reset leaves FAULT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_RUN;
        else        state <= state_next;
    end

    // Wait counter. It clears on entry to MEM_WAIT and counts each not-ready cycle spent there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if ((state == ST_RUN) && (state_next == ST_MEM_WAIT)) begin
            wait_cnt <= '0;
        end else if ((state == ST_MEM_WAIT) && !mem_ready) begin
            wait_cnt <= wait_cnt + COUNT_W'(1);
        end
    end

    // Stall counter. It counts every edge with the PC held and saturates instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (!pc_load_enable && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl.
// Instance A uses the default parameters. Instance B uses COUNT_W=3 and
// MEM_TIMEOUT=4 to exercise the timeout and saturation corner cases.
// The driver applies each vector and queues its expected outputs.
// The monitor pops and compares one entry per cycle.
module tb_pipeline_hazard_ctrl;

    localparam int W = 24;  // {sel, pc, ifid, flush, idex, nop, hold, fault, count[15:0]}

    // Expected flag patterns: {pc, ifid, flush, idex, nop, hold, fault}
    localparam logic [6:0] F_NORM  = 7'b1101000;
    localparam logic [6:0] F_STALL = 7'b0001100;
    localparam logic [6:0] F_BRFL  = 7'b1111100;
    localparam logic [6:0] F_FRZ   = 7'b0000010;
    localparam logic [6:0] F_FRZF  = 7'b0000011;
    localparam logic [6:0] F_RST   = 7'b0010100;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic [3:0] id_rn, id_rm, ex_rd;
    logic id_uses_rn, id_uses_rm;
    logic ex_reg_write_enable, ex_mem_enable, ex_mem_rw;
    logic branch_taken, mem_req, mem_ready;

    logic a_pc, a_ifid, a_flush, a_idex, a_nop, a_hold, a_fault;
    logic [15:0] a_cnt;
    logic [1:0]  a_state;
    logic b_pc, b_ifid, b_flush, b_idex, b_nop, b_hold, b_fault;
    logic [2:0]  b_cnt;
    logic [1:0]  b_state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_vec;
    int           n_miss;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .COUNT_W(16)) dut_a (
        .clk(clk), .reset(rst_a),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .ex_rd(ex_rd), .ex_reg_write_enable(ex_reg_write_enable),
        .ex_mem_enable(ex_mem_enable), .ex_mem_rw(ex_mem_rw),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_load_enable(a_pc), .if_id_load_enable(a_ifid), .if_id_flush(a_flush),
        .id_ex_load_enable(a_idex), .id_ex_nop_select(a_nop), .ex_mem_hold(a_hold),
        .mem_fault(a_fault), .stall_count(a_cnt), .fsm_state(a_state)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .COUNT_W(3)) dut_b (
        .clk(clk), .reset(rst_b),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .ex_rd(ex_rd), .ex_reg_write_enable(ex_reg_write_enable),
        .ex_mem_enable(ex_mem_enable), .ex_mem_rw(ex_mem_rw),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_load_enable(b_pc), .if_id_load_enable(b_ifid), .if_id_flush(b_flush),
        .id_ex_load_enable(b_idex), .id_ex_nop_select(b_nop), .ex_mem_hold(b_hold),
        .mem_fault(b_fault), .stall_count(b_cnt), .fsm_state(b_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] rn, input logic [3:0] rm, input logic urn,
                          input logic urm, input logic [3:0] rd, input logic rwe,
                          input logic men, input logic rw, input logic br,
                          input logic mreq, input logic mrdy);
        id_rn = rn; id_rm = rm; id_uses_rn = urn; id_uses_rm = urm; ex_rd = rd;
        ex_reg_write_enable = rwe; ex_mem_enable = men; ex_mem_rw = rw;
        branch_taken = br; mem_req = mreq; mem_ready = mrdy;
    endtask

    task automatic idle();
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_v(input string name, input logic sel, input logic [6:0] f,
                            input int cnt);
        exp_q.push_back({sel, f, cnt[15:0]});
        name_q.push_back(name);
    endtask

    // Scoreboard monitor: compares one queued expectation per falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] act;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e[23])
                act = {1'b1, b_pc, b_ifid, b_flush, b_idex, b_nop, b_hold, b_fault, 13'd0, b_cnt};
            else
                act = {1'b0, a_pc, a_ifid, a_flush, a_idex, a_nop, a_hold, a_fault, a_cnt};
            n_vec = n_vec + 1;
            if (act !== e) begin
                n_miss = n_miss + 1;
                $display("FAIL %s: got flags=%b cnt=%0d, want flags=%b cnt=%0d",
                         nm, act[22:16], act[15:0], e[22:16], e[15:0]);
            end
        end
    end

    // Stimulus
    initial begin
        n_vec = 0;
        n_miss = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        idle();

        // Instance A: reset, load-use, non-hazards, branch, memory wait
        go(); expect_v("a_reset", 1'b0, F_RST, 0);
        go(); rst_a = 1'b1; idle(); expect_v("a_idle", 1'b0, F_NORM, 0);
        go(); set_in(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_v("load_use_rn", 1'b0, F_STALL, 0);
        go(); idle(); expect_v("after_bubble", 1'b0, F_NORM, 1);
        go(); set_in(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_v("store_no_stall", 1'b0, F_NORM, 1);
        go(); set_in(4'd3, 4'd4, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_v("load_other_reg", 1'b0, F_NORM, 1);
        go(); set_in(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_v("branch_over_lu", 1'b0, F_BRFL, 1);
        go(); idle(); expect_v("after_branch", 1'b0, F_NORM, 1);
        for (int i = 0; i < 3; i++) begin
            go(); set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            expect_v("mem_wait_freeze", 1'b0, F_FRZ, 1 + i);
        end
        go(); set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        expect_v("mem_ready_frozen", 1'b0, F_FRZ, 4);
        go(); idle(); expect_v("after_wait", 1'b0, F_NORM, 5);
        go(); set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_v("single_cycle_mem", 1'b0, F_NORM, 5);
        go(); idle(); expect_v("after_single", 1'b0, F_NORM, 5);
        go(); set_in(4'd1, 4'd7, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_v("load_use_rm", 1'b0, F_STALL, 5);
        go(); idle(); expect_v("after_rm_bubble", 1'b0, F_NORM, 6);

        // Instance B: timeout to fault, saturation, async reset, ready wins over timeout
        go(); rst_a = 1'b0; expect_v("b_reset", 1'b1, F_RST, 0);
        go(); rst_b = 1'b1;
        set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_v("b_wait_run", 1'b1, F_FRZ, 0);
        for (int i = 1; i <= 4; i++) begin
            go(); expect_v("b_wait_pre_fault", 1'b1, F_FRZ, i);
        end
        go(); expect_v("b_fault_set", 1'b1, F_FRZF, 5);
        go(); expect_v("b_fault_sticky", 1'b1, F_FRZF, 6);
        go(); expect_v("b_sat_reach", 1'b1, F_FRZF, 7);
        go(); mem_ready = 1'b1; expect_v("b_sat_hold", 1'b1, F_FRZF, 7);
        go(); expect_v("b_fault_no_exit", 1'b1, F_FRZF, 7);
        go(); rst_b = 1'b0; expect_v("b_async_reset", 1'b1, F_RST, 0);
        go(); rst_b = 1'b1; idle(); expect_v("b_after_reset", 1'b1, F_NORM, 0);
        go(); set_in(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_v("b_wait2_run", 1'b1, F_FRZ, 0);
        for (int i = 1; i <= 3; i++) begin
            go(); expect_v("b_wait2", 1'b1, F_FRZ, i);
        end
        go(); mem_ready = 1'b1; expect_v("b_ready_wins", 1'b1, F_FRZ, 4);
        go(); idle(); expect_v("b_back_to_run", 1'b1, F_NORM, 5);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_vec = n_vec + 1;
            n_miss = n_miss + 1;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
